// File: rtl/sdr_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdr_port_arbiter
//
// Purpose:
//   Round-robin arbiter and transfer sequencer sitting between two host ports
//   and the single SDRAM command path. A granted request is captured into the
//   command registers and issued with a valid/ready handshake. The granted
//   port then receives a per-beat data strobe that starts the cycle after the
//   command path's data-start pulse, followed by a one-cycle completion pulse.
//
// Ports:
//   CLK, RESET_N              clock, asynchronous active-low reset
//   Pn_REQ/WR/ADDR/LEN        port n request and its captured fields
//   Pn_ACK                    one-cycle pulse: request accepted
//   Pn_DSTB                   beat strobe (write: present next word,
//                             read: read data valid)
//   Pn_DONE                   one-cycle pulse: transfer complete
//   CMD_VALID/WR/ADDR/LEN     command to the SDRAM command path
//   CMD_READY                 command path accepts on VALID & READY
//   CMD_DSTART                first data beat due next cycle
//   CMD_DONE                  command path finished the burst
// ---------------------------------------------------------------------------
module sdr_port_arbiter #(
    parameter int ASIZE = 23,
    parameter int LEN_W = 9
) (
    input  logic             CLK,
    input  logic             RESET_N,

    input  logic             P0_REQ,
    input  logic             P0_WR,
    input  logic [ASIZE-1:0] P0_ADDR,
    input  logic [LEN_W-1:0] P0_LEN,
    output logic             P0_ACK,
    output logic             P0_DSTB,
    output logic             P0_DONE,

    input  logic             P1_REQ,
    input  logic             P1_WR,
    input  logic [ASIZE-1:0] P1_ADDR,
    input  logic [LEN_W-1:0] P1_LEN,
    output logic             P1_ACK,
    output logic             P1_DSTB,
    output logic             P1_DONE,

    output logic             CMD_VALID,
    output logic             CMD_WR,
    output logic [ASIZE-1:0] CMD_ADDR,
    output logic [LEN_W-1:0] CMD_LEN,
    input  logic             CMD_READY,
    input  logic             CMD_DSTART,
    input  logic             CMD_DONE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DATA   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Registered state
    state_t             r_state;
    logic               r_gnt;          // port currently being serviced
    logic               r_last;         // port granted most recently
    logic [1:0]         r_ack;
    logic [1:0]         r_dstb;
    logic [1:0]         r_done;
    logic               r_cmd_valid;
    logic               r_cmd_wr;
    logic [ASIZE-1:0]   r_cmd_addr;
    logic [LEN_W-1:0]   r_cmd_len;
    logic [LEN_W-1:0]   r_cnt;          // beats still to strobe
    logic               r_cdone_seen;   // completion already known

    // Next-state values
    state_t             w_state_next;
    logic               w_gnt_next;
    logic               w_last_next;
    logic [1:0]         w_ack_next;
    logic [1:0]         w_dstb_next;
    logic [1:0]         w_done_next;
    logic               w_cmd_valid_next;
    logic               w_cmd_wr_next;
    logic [ASIZE-1:0]   w_cmd_addr_next;
    logic [LEN_W-1:0]   w_cmd_len_next;
    logic [LEN_W-1:0]   w_cnt_next;
    logic               w_cdone_seen_next;

    // Arbitration: a lone request wins outright; on a tie the port that was
    // not granted last wins.
    logic               w_any_req;
    logic               w_sel;
    logic [1:0]         w_sel_hot;
    logic [1:0]         w_gnt_hot;
    logic               w_sel_wr;
    logic [ASIZE-1:0]   w_sel_addr;
    logic [LEN_W-1:0]   w_sel_len;

    assign w_any_req  = P0_REQ | P1_REQ;
    assign w_sel      = (P0_REQ & P1_REQ) ? ~r_last : P1_REQ;
    assign w_sel_hot  = w_sel ? 2'b10 : 2'b01;
    assign w_gnt_hot  = r_gnt ? 2'b10 : 2'b01;
    assign w_sel_wr   = w_sel ? P1_WR   : P0_WR;
    assign w_sel_addr = w_sel ? P1_ADDR : P0_ADDR;
    assign w_sel_len  = w_sel ? P1_LEN  : P0_LEN;

    always_comb begin
        w_state_next      = r_state;
        w_gnt_next        = r_gnt;
        w_last_next       = r_last;
        w_ack_next        = 2'b00;
        w_dstb_next       = r_dstb;
        w_done_next       = 2'b00;
        w_cmd_valid_next  = r_cmd_valid;
        w_cmd_wr_next     = r_cmd_wr;
        w_cmd_addr_next   = r_cmd_addr;
        w_cmd_len_next    = r_cmd_len;
        w_cnt_next        = r_cnt;
        w_cdone_seen_next = r_cdone_seen;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_gnt_next      = w_sel;
                    w_ack_next      = w_sel_hot;
                    w_cmd_wr_next   = w_sel_wr;
                    w_cmd_addr_next = w_sel_addr;
                    w_cmd_len_next  = w_sel_len;
                    if (w_sel_len == '0) begin
                        // Zero-length burst: nothing to issue, so treat the
                        // transfer as already complete and go straight to
                        // FINISH, which pulses DONE on the next cycle.
                        w_cdone_seen_next = 1'b1;
                        w_state_next      = FINISH;
                    end else begin
                        w_cdone_seen_next = 1'b0;
                        w_state_next      = ISSUE;
                    end
                end
            end

            ISSUE: begin
                // First ISSUE cycle carries the ACK; VALID rises after it.
                if (!r_cmd_valid) begin
                    w_cmd_valid_next = 1'b1;
                end else if (CMD_READY) begin
                    w_cmd_valid_next = 1'b0;
                    w_cnt_next       = r_cmd_len;
                    w_state_next     = DATA;
                end
            end

            DATA: begin
                w_cdone_seen_next = r_cdone_seen | CMD_DONE;
                if (r_dstb == 2'b00) begin
                    // DSTART during an active run never reaches here.
                    if (CMD_DSTART) begin
                        w_dstb_next = w_gnt_hot;
                    end
                end else begin
                    w_cnt_next = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_dstb_next  = 2'b00;
                        w_state_next = FINISH;
                        // Completion already known: DONE follows the last
                        // beat directly.
                        if (r_cdone_seen | CMD_DONE) begin
                            w_done_next = w_gnt_hot;
                            w_last_next = r_gnt;
                        end
                    end
                end
            end

            FINISH: begin
                // The DONE cycle is spent here so a REQ still high alongside
                // DONE is not sampled; arbitration resumes from IDLE.
                if (r_done != 2'b00) begin
                    w_state_next = IDLE;
                end else if (r_cdone_seen | CMD_DONE) begin
                    w_done_next = w_gnt_hot;
                    w_last_next = r_gnt;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_gnt        <= 1'b0;
            r_last       <= 1'b1;
            r_ack        <= 2'b00;
            r_dstb       <= 2'b00;
            r_done       <= 2'b00;
            r_cmd_valid  <= 1'b0;
            r_cmd_wr     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_cnt        <= '0;
            r_cdone_seen <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_gnt        <= w_gnt_next;
            r_last       <= w_last_next;
            r_ack        <= w_ack_next;
            r_dstb       <= w_dstb_next;
            r_done       <= w_done_next;
            r_cmd_valid  <= w_cmd_valid_next;
            r_cmd_wr     <= w_cmd_wr_next;
            r_cmd_addr   <= w_cmd_addr_next;
            r_cmd_len    <= w_cmd_len_next;
            r_cnt        <= w_cnt_next;
            r_cdone_seen <= w_cdone_seen_next;
        end
    end

    assign P0_ACK    = r_ack[0];
    assign P1_ACK    = r_ack[1];
    assign P0_DSTB   = r_dstb[0];
    assign P1_DSTB   = r_dstb[1];
    assign P0_DONE   = r_done[0];
    assign P1_DONE   = r_done[1];
    assign CMD_VALID = r_cmd_valid;
    assign CMD_WR    = r_cmd_wr;
    assign CMD_ADDR  = r_cmd_addr;
    assign CMD_LEN   = r_cmd_len;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdr_port_arbiter
//
// Directed bench for sdr_port_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are checked at that point, so every check sees the
// registers loaded by the edge just passed.
// ---------------------------------------------------------------------------
module tb_sdr_port_arbiter;

    localparam int ASIZE = 23;
    localparam int LEN_W = 9;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;

    logic             P0_REQ = 1'b0;
    logic             P0_WR = 1'b0;
    logic [ASIZE-1:0] P0_ADDR = '0;
    logic [LEN_W-1:0] P0_LEN = '0;
    logic             P0_ACK;
    logic             P0_DSTB;
    logic             P0_DONE;

    logic             P1_REQ = 1'b0;
    logic             P1_WR = 1'b0;
    logic [ASIZE-1:0] P1_ADDR = '0;
    logic [LEN_W-1:0] P1_LEN = '0;
    logic             P1_ACK;
    logic             P1_DSTB;
    logic             P1_DONE;

    logic             CMD_VALID;
    logic             CMD_WR;
    logic [ASIZE-1:0] CMD_ADDR;
    logic [LEN_W-1:0] CMD_LEN;
    logic             CMD_READY = 1'b1;
    logic             CMD_DSTART = 1'b0;
    logic             CMD_DONE = 1'b0;

    logic [1:0]       ack;
    logic [1:0]       dstb;
    logic [1:0]       done;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [1:0]       exp_hot;

    assign ack  = {P1_ACK,  P0_ACK};
    assign dstb = {P1_DSTB, P0_DSTB};
    assign done = {P1_DONE, P0_DONE};

    sdr_port_arbiter #(
        .ASIZE (ASIZE),
        .LEN_W (LEN_W)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .P0_REQ     (P0_REQ),
        .P0_WR      (P0_WR),
        .P0_ADDR    (P0_ADDR),
        .P0_LEN     (P0_LEN),
        .P0_ACK     (P0_ACK),
        .P0_DSTB    (P0_DSTB),
        .P0_DONE    (P0_DONE),
        .P1_REQ     (P1_REQ),
        .P1_WR      (P1_WR),
        .P1_ADDR    (P1_ADDR),
        .P1_LEN     (P1_LEN),
        .P1_ACK     (P1_ACK),
        .P1_DSTB    (P1_DSTB),
        .P1_DONE    (P1_DONE),
        .CMD_VALID  (CMD_VALID),
        .CMD_WR     (CMD_WR),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_LEN    (CMD_LEN),
        .CMD_READY  (CMD_READY),
        .CMD_DSTART (CMD_DSTART),
        .CMD_DONE   (CMD_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ack",   32'(ack),       32'd0);
        chk("rst_dstb",  32'(dstb),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_valid", 32'(CMD_VALID), 32'd0);
        chk("rst_wr",    32'(CMD_WR),    32'd0);
        chk("rst_addr",  32'(CMD_ADDR),  32'd0);
        chk("rst_len",   32'(CMD_LEN),   32'd0);
        RESET_N = 1'b1;
        step();

        // ---------------- T1: single P0 write, LEN=4 ----------------
        P0_REQ = 1'b1; P0_WR = 1'b1; P0_ADDR = 23'h01234; P0_LEN = 9'd4;
        step();
        chk("t1_ack",    32'(ack),       32'd1);
        chk("t1_valid0", 32'(CMD_VALID), 32'd0);
        P0_REQ = 1'b0;
        step();
        chk("t1_ack_drop", 32'(ack),       32'd0);
        chk("t1_valid",    32'(CMD_VALID), 32'd1);
        chk("t1_wr",       32'(CMD_WR),    32'd1);
        chk("t1_addr",     32'(CMD_ADDR),  32'h01234);
        chk("t1_len",      32'(CMD_LEN),   32'd4);
        step();
        chk("t1_valid_drop", 32'(CMD_VALID), 32'd0);
        step();
        step();
        chk("t1_no_early_dstb", 32'(dstb), 32'd0);
        CMD_DSTART = 1'b1;
        step();
        CMD_DSTART = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_dstb_beat", 32'(dstb), 32'd1);
            chk("t1_no_done",   32'(done), 32'd0);
            step();
        end
        chk("t1_dstb_end", 32'(dstb), 32'd0);
        chk("t1_wait_done", 32'(done), 32'd0);
        CMD_DONE = 1'b1;
        step();
        CMD_DONE = 1'b0;
        chk("t1_done", 32'(done), 32'd1);
        step();
        chk("t1_done_drop", 32'(done), 32'd0);
        $display("txn T1: port 0 write len 4 complete");

        // ---------------- T2: simultaneous requests alternate ----------------
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        step();
        P0_WR = 1'b1; P0_ADDR = 23'h000A0; P0_LEN = 9'd2;
        P1_WR = 1'b0; P1_ADDR = 23'h000B1; P1_LEN = 9'd2;
        for (int t = 0; t < 4; t++) begin
            exp_hot = (t % 2 == 0) ? 2'b01 : 2'b10;
            P0_REQ = 1'b1; P1_REQ = 1'b1;
            step();
            chk("t2_ack", 32'(ack), 32'(exp_hot));
            chk("t2_addr", 32'(CMD_ADDR), (t % 2 == 0) ? 32'h000A0 : 32'h000B1);
            if (t % 2 == 0) P0_REQ = 1'b0; else P1_REQ = 1'b0;
            step();
            chk("t2_valid", 32'(CMD_VALID), 32'd1);
            step();
            CMD_DSTART = 1'b1;
            step();
            CMD_DSTART = 1'b0;
            chk("t2_dstb_b1", 32'(dstb), 32'(exp_hot));
            step();
            chk("t2_dstb_b2", 32'(dstb), 32'(exp_hot));
            CMD_DONE = 1'b1;
            step();
            CMD_DONE = 1'b0;
            chk("t2_dstb_end", 32'(dstb), 32'd0);
            chk("t2_done",     32'(done), 32'(exp_hot));
            step();
            chk("t2_done_drop", 32'(done), 32'd0);
            $display("txn T2.%0d: tie granted port %0d", t, (t % 2));
        end

        // ---------------- T3: CMD_READY held low 10 cycles ----------------
        // P0_REQ is still high from the last tie round.
        P0_WR = 1'b0; P0_ADDR = 23'h7ABCD; P0_LEN = 9'd7;
        CMD_READY = 1'b0;
        step();
        chk("t3_ack", 32'(ack), 32'd1);
        P0_REQ = 1'b0;
        step();
        chk("t3_valid", 32'(CMD_VALID), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_valid", 32'(CMD_VALID), 32'd1);
            chk("t3_hold_addr",  32'(CMD_ADDR),  32'h7ABCD);
            chk("t3_hold_len",   32'(CMD_LEN),   32'd7);
            chk("t3_hold_wr",    32'(CMD_WR),    32'd0);
            chk("t3_hold_dstb",  32'(dstb),      32'd0);
        end
        CMD_READY = 1'b1;
        step();
        chk("t3_handshake", 32'(CMD_VALID), 32'd0);
        step();
        chk("t3_no_early_dstb", 32'(dstb), 32'd0);
        CMD_DSTART = 1'b1;
        step();
        CMD_DSTART = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("t3_dstb_beat", 32'(dstb), 32'd1);
            step();
        end
        chk("t3_dstb_end", 32'(dstb), 32'd0);
        CMD_DONE = 1'b1;
        step();
        CMD_DONE = 1'b0;
        chk("t3_done", 32'(done), 32'd1);
        step();
        $display("txn T3: port 0 read len 7 after stalled ready");

        // ---------------- T4: LEN=0 on P1 ----------------
        P1_REQ = 1'b1; P1_WR = 1'b1; P1_ADDR = 23'h00055; P1_LEN = 9'd0;
        step();
        chk("t4_ack",    32'(ack),       32'd2);
        chk("t4_valid0", 32'(CMD_VALID), 32'd0);
        P1_REQ = 1'b0;
        step();
        chk("t4_done",   32'(done),      32'd2);
        chk("t4_valid1", 32'(CMD_VALID), 32'd0);
        step();
        chk("t4_done_drop", 32'(done),      32'd0);
        chk("t4_valid2",    32'(CMD_VALID), 32'd0);
        step();
        chk("t4_valid3", 32'(CMD_VALID), 32'd0);
        $display("txn T4: port 1 zero-length request");

        // ---------------- T5: CMD_DONE early, LEN=8 ----------------
        P0_REQ = 1'b1; P0_WR = 1'b1; P0_ADDR = 23'h00100; P0_LEN = 9'd8;
        step();
        chk("t5_ack", 32'(ack), 32'd1);
        P0_REQ = 1'b0;
        step();
        step();
        CMD_DSTART = 1'b1;
        step();
        CMD_DSTART = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("t5_dstb_beat", 32'(dstb), 32'd1);
            chk("t5_no_done",   32'(done), 32'd0);
            if (i == 3) CMD_DONE = 1'b1;
            step();
            CMD_DONE = 1'b0;
        end
        chk("t5_dstb_end", 32'(dstb), 32'd0);
        chk("t5_done",     32'(done), 32'd1);
        step();
        chk("t5_done_drop", 32'(done), 32'd0);
        $display("txn T5: port 0 len 8 with early CMD_DONE");

        // ---------------- T6: reset during DATA, then P1 ----------------
        P0_REQ = 1'b1; P0_WR = 1'b0; P0_ADDR = 23'h00222; P0_LEN = 9'd5;
        step();
        chk("t6_ack", 32'(ack), 32'd1);
        P0_REQ = 1'b0;
        step();
        step();
        CMD_DSTART = 1'b1;
        step();
        CMD_DSTART = 1'b0;
        chk("t6_dstb_b1", 32'(dstb), 32'd1);
        step();
        chk("t6_dstb_b2", 32'(dstb), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_dstb",  32'(dstb),      32'd0);
        chk("t6_rst_done",  32'(done),      32'd0);
        chk("t6_rst_ack",   32'(ack),       32'd0);
        chk("t6_rst_valid", 32'(CMD_VALID), 32'd0);
        chk("t6_rst_addr",  32'(CMD_ADDR),  32'd0);
        chk("t6_rst_len",   32'(CMD_LEN),   32'd0);
        step();
        RESET_N = 1'b1;
        CMD_DONE = 1'b1;
        step();
        CMD_DONE = 1'b0;
        chk("t6_no_done_a", 32'(done), 32'd0);
        step();
        chk("t6_no_done_b", 32'(done), 32'd0);
        P1_REQ = 1'b1; P1_WR = 1'b1; P1_ADDR = 23'h002AA; P1_LEN = 9'd1;
        step();
        chk("t6_p1_ack", 32'(ack), 32'd2);
        P1_REQ = 1'b0;
        step();
        chk("t6_p1_valid", 32'(CMD_VALID), 32'd1);
        chk("t6_p1_addr",  32'(CMD_ADDR),  32'h002AA);
        step();
        CMD_DSTART = 1'b1;
        step();
        CMD_DSTART = 1'b0;
        chk("t6_p1_dstb", 32'(dstb), 32'd2);
        CMD_DONE = 1'b1;
        step();
        CMD_DONE = 1'b0;
        chk("t6_p1_dstb_end", 32'(dstb), 32'd0);
        chk("t6_p1_done",     32'(done), 32'd2);
        step();
        chk("t6_p1_done_drop", 32'(done), 32'd0);
        $display("txn T6: aborted port 0, then port 1 len 1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
